// File: rtl/elevator_pkg.sv
// Shared types and helpers for the lift call scheduler.
// Floor codes, travel direction, controller states and SCAN helpers.
package elevator_pkg;

  localparam logic [2:0] FLOOR_A = 3'd0;
  localparam logic [2:0] FLOOR_B = 3'd1;
  localparam logic [2:0] FLOOR_C = 3'd2;
  localparam logic [2:0] FLOOR_D = 3'd3;
  localparam logic [2:0] FLOOR_E = 3'd4;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  function automatic logic [4:0] floor_onehot(input logic [2:0] f);
    floor_onehot = 5'd0;
    for (int i = 0; i < 5; i++)
      if (f == 3'(i)) floor_onehot[i] = 1'b1;
  endfunction

  function automatic logic calls_above(input logic [4:0] p,
                                       input logic [2:0] f);
    calls_above = 1'b0;
    for (int i = 0; i < 5; i++)
      if (3'(i) > f && p[i]) calls_above = 1'b1;
  endfunction

  function automatic logic calls_below(input logic [4:0] p,
                                       input logic [2:0] f);
    calls_below = 1'b0;
    for (int i = 0; i < 5; i++)
      if (3'(i) < f && p[i]) calls_below = 1'b1;
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_timer.sv
// Shared travel/dwell counter for the lift scheduler.
// Clear wins over enable; the terminal compare lives in the parent.
module elevator_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a 5-floor lift car.
// Owns floor/dir, latches calls, times travel and door dwell.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int NFLOORS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ra,
  input  logic       rb,
  input  logic       rc,
  input  logic       rd,
  input  logic       re,
  output logic [2:0] floor,
  output logic       dir,
  output logic       moving,
  output logic       door_open,
  output logic [4:0] pending,
  output logic       served
);

  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                        TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [2:0] FLOOR_MAX = 3'(NFLOORS - 1);

  state_t state, state_n;
  logic [2:0] floor_n;
  logic dir_n, served_n;
  logic [4:0] pending_n, clr, here, req;
  logic [TW-1:0] tcount;
  logic tclr, ten, move_done, door_done, rereq;

  assign req       = {re, rd, rc, rb, ra};
  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

  elevator_timer #(.WIDTH(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tclr),
    .enable (ten),
    .count  (tcount)
  );

  always_comb begin
    state_n   = state;
    floor_n   = floor;
    dir_n     = dir;
    served_n  = 1'b0;
    clr       = 5'd0;
    tclr      = 1'b1;
    ten       = 1'b0;
    here      = floor_onehot(floor);
    move_done = (tcount == TW'(TRAVEL_CYCLES - 1));
    door_done = (tcount == TW'(DOOR_CYCLES - 1));
    rereq     = (state == DOOR) && |(req & here);
    if (floor > FLOOR_MAX) begin
      floor_n = FLOOR_A;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (|(pending & here)) begin
            state_n  = DOOR;
            clr      = here;
            served_n = 1'b1;
          end else if (dir == UP) begin
            if (calls_above(pending, floor)) begin
              state_n = MOVE;
            end else if (calls_below(pending, floor)) begin
              dir_n   = DOWN;
              state_n = MOVE;
            end
          end else begin
            if (calls_below(pending, floor)) begin
              state_n = MOVE;
            end else if (calls_above(pending, floor)) begin
              dir_n   = UP;
              state_n = MOVE;
            end
          end
        end
        MOVE: begin
          ten  = 1'b1;
          tclr = move_done;
          if (move_done) begin
            floor_n = (dir == UP) ? floor + 3'd1 : floor - 3'd1;
            state_n = IDLE;
          end
        end
        DOOR: begin
          ten  = 1'b1;
          tclr = door_done | rereq;
          if (door_done && !rereq) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    // a held door swallows presses for its own floor
    pending_n = (pending | (req & ~((state == DOOR) ? here : 5'd0)))
                & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      floor   <= FLOOR_A;
      dir     <= UP;
      pending <= 5'd0;
      served  <= 1'b0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir     <= dir_n;
      pending <= pending_n;
      served  <= served_n;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for the lift call scheduler.
// Directed call sequences with hand-timed state checkpoints.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = 5'd0;
  logic [2:0] floor;
  logic       dir, moving, door_open, served;
  logic [4:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] f;
    logic       d;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  elevator_call_scheduler #(
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (4),
    .NFLOORS       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (btn[0]),
    .rb        (btn[1]),
    .rc        (btn[2]),
    .rd        (btn[3]),
    .re        (btn[4]),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending),
    .served    (served)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic st(input string nm, input logic [2:0] f,
                    input logic d, input logic mv, input logic dr,
                    input logic [4:0] p);
    chk({nm, ".floor"},   8'(floor),     8'(f));
    chk({nm, ".dir"},     8'(dir),       8'(d));
    chk({nm, ".moving"},  8'(moving),    8'(mv));
    chk({nm, ".door"},    8'(door_open), 8'(dr));
    chk({nm, ".pending"}, 8'(pending),   8'(p));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    @(negedge clk);
    btn = 5'd0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && served === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL served_extra: served=1 at floor %0d, expected 0",
                 floor);
      end else begin
        e = sb.pop_front();
        chk("sb.floor", 8'(floor),     8'(e.f));
        chk("sb.dir",   8'(dir),       8'(e.d));
        chk("sb.door",  8'(door_open), 8'd1);
      end
    end
  end

  initial begin
    tick(2);
    st("reset", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("reset.served", 8'(served), 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick(1);
      st("idle", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    end

    sb.push_back('{3'd2, 1'b0});
    press(5'b00100);
    st("t2.e0", 3'd0, 1'b0, 1'b0, 1'b0, 5'b00100);
    tick(1);
    st("t2.e1", 3'd0, 1'b0, 1'b1, 1'b0, 5'b00100);
    tick(8);
    st("t2.e9", 3'd1, 1'b0, 1'b0, 1'b0, 5'b00100);
    tick(1);
    st("t2.e10", 3'd1, 1'b0, 1'b1, 1'b0, 5'b00100);
    tick(8);
    st("t2.e18", 3'd2, 1'b0, 1'b0, 1'b0, 5'b00100);
    tick(1);
    st("t2.e19", 3'd2, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("t2.served", 8'(served), 8'd1);
    tick(3);
    st("t2.e22", 3'd2, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(1);
    st("t2.e23", 3'd2, 1'b0, 1'b0, 1'b0, 5'd0);

    sb.push_back('{3'd4, 1'b0});
    sb.push_back('{3'd1, 1'b1});
    press(5'b10010);
    st("t3.e0", 3'd2, 1'b0, 1'b0, 1'b0, 5'b10010);
    tick(18);
    st("t3.e18", 3'd4, 1'b0, 1'b0, 1'b0, 5'b10010);
    tick(1);
    st("t3.e19", 3'd4, 1'b0, 1'b0, 1'b1, 5'b00010);
    tick(4);
    st("t3.e23", 3'd4, 1'b0, 1'b0, 1'b0, 5'b00010);
    tick(1);
    st("t3.e24", 3'd4, 1'b1, 1'b1, 1'b0, 5'b00010);
    tick(27);
    st("t3.e51", 3'd1, 1'b1, 1'b0, 1'b1, 5'd0);
    tick(4);
    st("t3.e55", 3'd1, 1'b1, 1'b0, 1'b0, 5'd0);

    sb.push_back('{3'd3, 1'b0});
    press(5'b01000);
    st("t4.e0", 3'd1, 1'b1, 1'b0, 1'b0, 5'b01000);
    tick(1);
    st("t4.e1", 3'd1, 1'b0, 1'b1, 1'b0, 5'b01000);
    tick(18);
    st("t4.e19", 3'd3, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(2);
    press(5'b01000);
    st("t4.e22", 3'd3, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("t4.noserve", 8'(served), 8'd0);
    tick(3);
    st("t4.e25", 3'd3, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(1);
    st("t4.e26", 3'd3, 1'b0, 1'b0, 1'b0, 5'd0);

    sb.push_back('{3'd1, 1'b1});
    press(5'b00010);
    st("t5.e0", 3'd3, 1'b0, 1'b0, 1'b0, 5'b00010);
    tick(1);
    st("t5.e1", 3'd3, 1'b1, 1'b1, 1'b0, 5'b00010);
    tick(18);
    st("t5.e19", 3'd1, 1'b1, 1'b0, 1'b1, 5'd0);
    tick(4);
    st("t5.e23", 3'd1, 1'b1, 1'b0, 1'b0, 5'd0);
    press(5'b00100);
    tick(6);
    st("t5.mid", 3'd1, 1'b0, 1'b1, 1'b0, 5'b00100);
    rst = 1'b1;
    btn = 5'b10000;
    tick(1);
    rst = 1'b0;
    btn = 5'd0;
    st("t5.rst", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t5.rst.served", 8'(served), 8'd0);
    tick(2);
    st("t5.hold", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    sb.push_back('{3'd1, 1'b0});
    press(5'b00010);
    tick(1);
    st("t5.r1", 3'd0, 1'b0, 1'b1, 1'b0, 5'b00010);
    tick(8);
    st("t5.r9", 3'd1, 1'b0, 1'b0, 1'b0, 5'b00010);
    tick(1);
    st("t5.r10", 3'd1, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(4);
    st("t5.r14", 3'd1, 1'b0, 1'b0, 1'b0, 5'd0);

    sb.push_back('{3'd4, 1'b0});
    press(5'b10000);
    tick(27);
    st("t6.up27", 3'd4, 1'b0, 1'b0, 1'b0, 5'b10000);
    tick(1);
    st("t6.up28", 3'd4, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(4);
    st("t6.up32", 3'd4, 1'b0, 1'b0, 1'b0, 5'd0);
    sb.push_back('{3'd3, 1'b1});
    sb.push_back('{3'd0, 1'b1});
    press(5'b00001);
    st("t6.e0", 3'd4, 1'b0, 1'b0, 1'b0, 5'b00001);
    tick(2);
    press(5'b01000);
    st("t6.e3", 3'd4, 1'b1, 1'b1, 1'b0, 5'b01001);
    tick(6);
    st("t6.e9", 3'd3, 1'b1, 1'b0, 1'b0, 5'b01001);
    tick(1);
    st("t6.e10", 3'd3, 1'b1, 1'b0, 1'b1, 5'b00001);
    tick(4);
    st("t6.e14", 3'd3, 1'b1, 1'b0, 1'b0, 5'b00001);
    tick(1);
    st("t6.e15", 3'd3, 1'b1, 1'b1, 1'b0, 5'b00001);
    tick(26);
    st("t6.e41", 3'd0, 1'b1, 1'b0, 1'b0, 5'b00001);
    tick(1);
    st("t6.e42", 3'd0, 1'b1, 1'b0, 1'b1, 5'd0);
    tick(8);
    st("t6.e50", 3'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    sb.push_back('{3'd4, 1'b0});
    press(5'b10000);
    tick(1);
    st("t6.rev", 3'd0, 1'b0, 1'b1, 1'b0, 5'b10000);
    tick(44);
    st("t6.end", 3'd4, 1'b0, 1'b0, 1'b0, 5'd0);

    chk("sb.drain", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
